// File: rtl/stage4_message_assemble_module_pkg.sv
// Shared definitions for the stage-4 message assembler: message geometry,
// stage-5 mux codes, market type bytes and the type-byte classifier.
package stage4_message_assemble_module_pkg;

  localparam int MAX_MESSAGE_BITS          = 256;
  localparam int MESSAGE_MUX_CONTROL_WIDTH = 2;

  typedef logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] mux_ctl_t;

  localparam mux_ctl_t MESSAGE_MUX_A    = 2'd0;
  localparam mux_ctl_t MESSAGE_MUX_D    = 2'd1;
  localparam mux_ctl_t MESSAGE_MUX_K    = 2'd2;
  localparam mux_ctl_t MESSAGE_MUX_NONE = '1;

  localparam logic [7:0] TYPE_BYTE_A = 8'h41;
  localparam logic [7:0] TYPE_BYTE_D = 8'h44;
  localparam logic [7:0] TYPE_BYTE_K = 8'h4B;

  // Unknown types map to NONE, which the assembler treats as "discard".
  function automatic mux_ctl_t type_to_mux(input logic [7:0] type_byte,
                                           input logic [7:0] type_a,
                                           input logic [7:0] type_d,
                                           input logic [7:0] type_k);
    if (type_byte == type_a)      return MESSAGE_MUX_A;
    else if (type_byte == type_d) return MESSAGE_MUX_D;
    else if (type_byte == type_k) return MESSAGE_MUX_K;
    else                          return MESSAGE_MUX_NONE;
  endfunction

endpackage

// File: rtl/stage4_word_packer_module.sv
// Packs word-serial input into an MSB-aligned message register and flags
// words that would fall beyond the end of the register.
module stage4_word_packer_module
  import stage4_message_assemble_module_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        write,
  input  logic [DATA_WIDTH-1:0]       word,
  output logic [MAX_MESSAGE_BITS-1:0] msg_next,
  output logic                        overlength
);

  localparam int WORDS = MAX_MESSAGE_BITS / DATA_WIDTH;
  localparam int IDX_W = $clog2(WORDS + 1);

  logic [MAX_MESSAGE_BITS-1:0] msg_q;
  logic [IDX_W-1:0]            idx_q, idx_d;

  assign overlength = (idx_q >= IDX_W'(WORDS));

  // NOTE: combinational blocks use blocking assignments and assign every
  // output a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    msg_next = msg_q;
    idx_d    = idx_q;
    if (start) begin
      msg_next = '0;
      msg_next[MAX_MESSAGE_BITS-1 -: DATA_WIDTH] = word;
      idx_d    = IDX_W'(1);
    end else if (write && !overlength) begin
      for (int k = 0; k < WORDS; k++) begin
        if (idx_q == IDX_W'(k)) msg_next[MAX_MESSAGE_BITS-1-k*DATA_WIDTH -: DATA_WIDTH] = word;
      end
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q <= '0;
      idx_q <= '0;
    end else begin
      msg_q <= msg_next;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/stage4_message_assemble_module.sv
// Assembles word-serial market messages, classifies them by type byte and
// presents groups of up to three to the stage-5 field extractors.
module stage4_message_assemble_module
  import stage4_message_assemble_module_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter logic [7:0] TYPE_A     = TYPE_BYTE_A,
  parameter logic [7:0] TYPE_D     = TYPE_BYTE_D,
  parameter logic [7:0] TYPE_K     = TYPE_BYTE_K,
  parameter int         TIMEOUT    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic                                 in_sop,
  input  logic                                 in_eop,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 flush,
  output logic                                 message_en,
  output logic [MAX_MESSAGE_BITS-1:0]          message_1,
  output logic [MAX_MESSAGE_BITS-1:0]          message_2,
  output logic [MAX_MESSAGE_BITS-1:0]          message_3,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m1,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m2,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m3,
  output logic                                 drop_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ASSEMBLE, ST_DROP} state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  type_q, type_d;
  logic                        start, write, complete, drop_d;
  logic [MAX_MESSAGE_BITS-1:0] asm_next;
  logic                        overlength;
  mux_ctl_t                    code;
  logic                        complete_ok;

  logic [MAX_MESSAGE_BITS-1:0] slot_msg_q [3];
  logic [MAX_MESSAGE_BITS-1:0] slot_msg_d [3];
  mux_ctl_t                    slot_ctl_q [3];
  mux_ctl_t                    slot_ctl_d [3];
  logic [1:0]                  slot_cnt_q, slot_cnt_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        tmo_hit, emit;

  stage4_word_packer_module #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .write     (write),
    .word      (in_data),
    .msg_next  (asm_next),
    .overlength(overlength)
  );

  // A sop is always honoured: it restarts assembly even mid-message or in DROP.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    write    = 1'b0;
    complete = 1'b0;
    drop_d   = 1'b0;
    if (in_valid) begin
      if (in_sop) begin
        start   = 1'b1;
        drop_d  = (state_q == ST_ASSEMBLE);
        state_d = in_eop ? ST_IDLE : ST_ASSEMBLE;
        complete = in_eop;
      end else begin
        case (state_q)
          ST_IDLE: drop_d = 1'b1;
          ST_ASSEMBLE: begin
            if (overlength) begin
              drop_d  = 1'b1;
              state_d = in_eop ? ST_IDLE : ST_DROP;
            end else begin
              write    = 1'b1;
              complete = in_eop;
              if (in_eop) state_d = ST_IDLE;
            end
          end
          ST_DROP: if (in_eop) state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
    type_d      = start ? in_data[DATA_WIDTH-1 -: 8] : type_q;
    code        = type_to_mux(type_d, TYPE_A, TYPE_D, TYPE_K);
    complete_ok = complete && (code != MESSAGE_MUX_NONE);
    if (complete && !complete_ok) drop_d = 1'b1;
  end

  // The completing message is folded into the group before the emit decision,
  // so a third eop coinciding with flush or timeout yields one emission.
  always_comb begin
    slot_msg_d = slot_msg_q;
    slot_ctl_d = slot_ctl_q;
    slot_cnt_d = slot_cnt_q;
    if (complete_ok) begin
      for (int i = 0; i < 3; i++) begin
        if (slot_cnt_q == 2'(i)) begin
          slot_msg_d[i] = asm_next;
          slot_ctl_d[i] = code;
        end
      end
      slot_cnt_d = slot_cnt_q + 2'd1;
    end
    tmo_hit = (tmo_q == TMO_W'(TIMEOUT)) && (slot_cnt_q != 2'd0);
    emit    = (slot_cnt_d == 2'd3) || (flush && slot_cnt_d != 2'd0) || tmo_hit;
    tmo_d   = tmo_q;
    if (emit || in_valid) tmo_d = '0;
    else if (state_q == ST_IDLE && slot_cnt_q != 2'd0 && tmo_q != TMO_W'(TIMEOUT))
      tmo_d = tmo_q + TMO_W'(1);
  end

  // NOTE: slot storage is reset along with control state because unused slots
  // must read as zero data and NONE codes when a partial group is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      type_q     <= '0;
      slot_cnt_q <= '0;
      tmo_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        slot_msg_q[i] <= '0;
        slot_ctl_q[i] <= MESSAGE_MUX_NONE;
      end
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      tmo_q   <= tmo_d;
      if (emit) begin
        slot_cnt_q <= '0;
        for (int i = 0; i < 3; i++) begin
          slot_msg_q[i] <= '0;
          slot_ctl_q[i] <= MESSAGE_MUX_NONE;
        end
      end else begin
        slot_cnt_q <= slot_cnt_d;
        slot_msg_q <= slot_msg_d;
        slot_ctl_q <= slot_ctl_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      message_en             <= 1'b0;
      drop_err               <= 1'b0;
      message_1              <= '0;
      message_2              <= '0;
      message_3              <= '0;
      message_mux_control_m1 <= MESSAGE_MUX_NONE;
      message_mux_control_m2 <= MESSAGE_MUX_NONE;
      message_mux_control_m3 <= MESSAGE_MUX_NONE;
    end else begin
      message_en <= emit;
      drop_err   <= drop_d;
      if (emit) begin
        message_1              <= slot_msg_d[0];
        message_2              <= slot_msg_d[1];
        message_3              <= slot_msg_d[2];
        message_mux_control_m1 <= slot_ctl_d[0];
        message_mux_control_m2 <= slot_ctl_d[1];
        message_mux_control_m3 <= slot_ctl_d[2];
      end
    end
  end

endmodule

// File: tb/tb_stage4_message_assemble_module.sv
// Scoreboard bench for the stage-4 assembler: expected groups are queued as
// messages are driven and compared, with their due cycle, on each message_en.
module tb_stage4_message_assemble_module;
  import stage4_message_assemble_module_pkg::*;

  localparam int DW    = 64;
  localparam int MB    = MAX_MESSAGE_BITS;
  localparam int WORDS = MB / DW;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          message_en, drop_err;
  logic [MB-1:0] message_1, message_2, message_3;
  logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m1, message_mux_control_m2,
                                        message_mux_control_m3;

  stage4_message_assemble_module #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .flush(flush), .message_en(message_en),
    .message_1(message_1), .message_2(message_2), .message_3(message_3),
    .message_mux_control_m1(message_mux_control_m1),
    .message_mux_control_m2(message_mux_control_m2),
    .message_mux_control_m3(message_mux_control_m3),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [MB-1:0] m1, m2, m3;
    logic [1:0]    c1, c2, c3;
    logic [31:0]   due;
  } grp_t;

  grp_t          exp_q[$];
  logic [MB-1:0] mdl_msg [3];
  logic [1:0]    mdl_ctl [3];
  int            mdl_cnt = 0;
  int            last_cyc = 0;

  task automatic check(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [1:0] exp_code(input logic [7:0] t);
    case (t)
      8'h41:   return MESSAGE_MUX_A;
      8'h44:   return MESSAGE_MUX_D;
      8'h4B:   return MESSAGE_MUX_K;
      default: return MESSAGE_MUX_NONE;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mdl_msg[i] = '0;
      mdl_ctl[i] = MESSAGE_MUX_NONE;
    end
    mdl_cnt = 0;
  endtask

  task automatic model_emit(input int due);
    grp_t g;
    g.m1 = mdl_msg[0]; g.m2 = mdl_msg[1]; g.m3 = mdl_msg[2];
    g.c1 = mdl_ctl[0]; g.c2 = mdl_ctl[1]; g.c3 = mdl_ctl[2];
    g.due = 32'(due);
    exp_q.push_back(g);
    model_clear();
  endtask

  task automatic model_push(input logic [MB-1:0] m, input logic [1:0] c);
    mdl_msg[mdl_cnt] = m;
    mdl_ctl[mdl_cnt] = c;
    mdl_cnt++;
    if (mdl_cnt == 3) model_emit(last_cyc + 1);
  endtask

  task automatic send_word(input bit sop, input bit eop, input logic [DW-1:0] d,
                           input bit exp_drop, input bit fl);
    @(negedge clk);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d; flush = fl;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; flush = 1'b0;
    check("drop_err", drop_err, exp_drop);
  endtask

  function automatic logic [DW-1:0] rand_word(input logic [7:0] typ, input bit typed);
    logic [31:0]   r1, r2;
    logic [DW-1:0] w;
    r1 = $urandom; r2 = $urandom;
    w = {r1, r2};
    if (typed) w[DW-1 -: 8] = typ;
    return w;
  endfunction

  task automatic send_msg(input logic [7:0] typ, input int n, input bit fl);
    logic [MB-1:0] m;
    logic [DW-1:0] w;
    logic [1:0]    c;
    m = '0;
    c = exp_code(typ);
    for (int k = 0; k < n; k++) begin
      w = rand_word(typ, k == 0);
      m[MB-1-k*DW -: DW] = w;
      send_word(k == 0, k == n - 1, w, (k == n - 1) && (c == MESSAGE_MUX_NONE), fl && (k == n - 1));
    end
    if (c != MESSAGE_MUX_NONE) model_push(m, c);
    if (fl && mdl_cnt > 0) model_emit(last_cyc + 1);
  endtask

  task automatic do_flush();
    int drive_cyc;
    @(negedge clk);
    flush = 1'b1;
    drive_cyc = cyc;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (mdl_cnt > 0) model_emit(drive_cyc + 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && message_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_en", message_en, 1'b0);
      end else begin
        grp_t e;
        e = exp_q.pop_front();
        check("latency", cyc, e.due);
        check("message_1", message_1, e.m1);
        check("message_2", message_2, e.m2);
        check("message_3", message_3, e.m3);
        check("mux_m1", message_mux_control_m1, e.c1);
        check("mux_m2", message_mux_control_m2, e.c2);
        check("mux_m3", message_mux_control_m3, e.c3);
      end
    end
  end

  initial begin
    logic [MB-1:0] m;
    logic [DW-1:0] w;
    model_clear();

    repeat (3) @(negedge clk);
    check("rst_en", message_en, 1'b0);
    check("rst_drop", drop_err, 1'b0);
    check("rst_msg1", message_1, '0);
    check("rst_msg3", message_3, '0);
    check("rst_m1", message_mux_control_m1, MESSAGE_MUX_NONE);
    check("rst_m2", message_mux_control_m2, MESSAGE_MUX_NONE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three single-word messages back to back.
    send_msg(8'h41, 1, 1'b0);
    send_msg(8'h44, 1, 1'b0);
    send_msg(8'h4B, 1, 1'b0);
    // Lands in the new group's slot 0 during the emission cycle.
    send_msg(8'h44, 1, 1'b0);
    do_flush();

    // Timeout flush of a partial group.
    send_msg(8'h41, 2, 1'b0);
    model_emit(last_cyc + TMO + 2);
    repeat (TMO + 6) @(negedge clk);

    // Unknown type discarded, stray word outside a message, flush on empty group.
    send_msg(8'h5A, 2, 1'b0);
    send_word(1'b0, 1'b1, rand_word(8'h00, 1'b0), 1'b1, 1'b0);
    do_flush();
    send_msg(8'h41, 2, 1'b0);
    send_msg(8'h44, WORDS, 1'b0);
    send_msg(8'h4B, 3, 1'b0);

    // Overlength message: drop on the overflow word, then ignore to eop.
    send_word(1'b1, 1'b0, rand_word(8'h41, 1'b1), 1'b0, 1'b0);
    for (int k = 1; k < WORDS; k++) send_word(1'b0, 1'b0, rand_word(8'h00, 1'b0), 1'b0, 1'b0);
    send_word(1'b0, 1'b0, rand_word(8'h00, 1'b0), 1'b1, 1'b0);
    send_word(1'b0, 1'b0, rand_word(8'h00, 1'b0), 1'b0, 1'b0);
    send_word(1'b0, 1'b1, rand_word(8'h00, 1'b0), 1'b0, 1'b0);
    send_msg(8'h41, 3, 1'b0);
    do_flush();

    // sop mid-message restarts assembly from the new word.
    send_word(1'b1, 1'b0, rand_word(8'h41, 1'b1), 1'b0, 1'b0);
    send_word(1'b0, 1'b0, rand_word(8'h00, 1'b0), 1'b0, 1'b0);
    m = '0;
    w = rand_word(8'h44, 1'b1);
    m[MB-1 -: DW] = w;
    send_word(1'b1, 1'b0, w, 1'b1, 1'b0);
    w = rand_word(8'h00, 1'b0);
    m[MB-1-DW -: DW] = w;
    send_word(1'b0, 1'b1, w, 1'b0, 1'b0);
    model_push(m, MESSAGE_MUX_D);
    do_flush();

    // Third eop coinciding with flush gives a single emission.
    send_msg(8'h4B, 1, 1'b0);
    send_msg(8'h41, 2, 1'b0);
    send_msg(8'h44, 1, 1'b1);
    repeat (3) @(negedge clk);

    // Reset with two slots filled and a message half assembled.
    send_msg(8'h41, 1, 1'b0);
    send_msg(8'h44, 2, 1'b0);
    send_word(1'b1, 1'b0, rand_word(8'h4B, 1'b1), 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_en", message_en, 1'b0);
    check("mid_rst_msg1", message_1, '0);
    check("mid_rst_msg2", message_2, '0);
    check("mid_rst_m1", message_mux_control_m1, MESSAGE_MUX_NONE);
    check("mid_rst_m3", message_mux_control_m3, MESSAGE_MUX_NONE);
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (TMO + 8) @(negedge clk);

    // Post-reset assembly still works.
    send_msg(8'h4B, 2, 1'b0);
    do_flush();
    repeat (4) @(negedge clk);

    check("pending_groups", 256'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stage4_message_assemble_module.md
Name: stage4_message_assemble_module

Overview:
- Stage directly upstream of the stage-5 field extractors.
- Assembles word-serial market messages into full-width message registers and classifies each by its type byte into a/d/k mux codes.
- Groups up to three messages and presents them on message_1..3 with message_mux_control_m1..3 and a one-cycle message_en strobe.
- Stage-5 field extraction is combinational and consumes the registered outputs directly.

Parameters:
- DATA_WIDTH, 64, input word width in bits; `MAX_MESSAGE_BITS must be an integer multiple of it.
- TYPE_A, 8'h41, type byte mapped to `message_mux_a.
- TYPE_D, 8'h44, type byte mapped to `message_mux_d.
- TYPE_K, 8'h4B, type byte mapped to `message_mux_k.
- TIMEOUT, 16, idle cycles before a partial group is flushed; must be >= 1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data word valid this cycle.
- in_sop  in  1  first word of a message; qualified by in_valid.
- in_eop  in  1  last word of a message; qualified by in_valid; may coincide with in_sop.
- in_data  in  DATA_WIDTH  message word, first byte in MSBs.
- flush  in  1  emit any partial group on the next cycle.
- message_en  out  1  one-cycle strobe: group valid.
- message_1, message_2, message_3  out  `MAX_MESSAGE_BITS each  assembled messages, MSB-aligned.
- message_mux_control_m1, message_mux_control_m2, message_mux_control_m3  out  `message_mux_control_width each  type code per slot.
- drop_err  out  1  one-cycle pulse when a message is discarded.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0.
  - Mux controls = `message_mux_none.
  - FSM to IDLE; slot count, word index and timeout counter cleared.
- FSM states: IDLE, ASSEMBLE, DROP.
- IDLE:
  - in_valid & in_sop: clear assembly register, write word 0, latch type byte in_data[DATA_WIDTH-1 -: 8].
  - Go to ASSEMBLE, or finish the message immediately if in_eop is also high.
  - in_valid without in_sop: word ignored, drop_err pulses.
- ASSEMBLE:
  - Word k is written at bits [`MAX_MESSAGE_BITS-1-k*DATA_WIDTH -: DATA_WIDTH].
  - Unwritten bits remain 0.
  - A word at index >= `MAX_MESSAGE_BITS/DATA_WIDTH (overlength): go to DROP, drop_err pulses.
  - in_sop before in_eop: pulse drop_err, discard the partial message, start the new message from this word.
- DROP: ignore words until in_valid & in_eop, then go to IDLE. in_sop seen here is handled as in IDLE.
- Message completion (in_eop accepted in ASSEMBLE or IDLE):
  - Type byte equals TYPE_A/D/K: message copied into slot[slot_cnt] with its mux code, slot_cnt increments.
  - Any other type: discarded, drop_err pulses, no slot used.
- Emission:
  - Triggers: slot_cnt reaches 3; flush with slot_cnt > 0; timeout counter reaching TIMEOUT with slot_cnt > 0.
  - On the next cycle, output registers load all three slots and message_en = 1 for exactly that cycle.
  - Unused slots output all-zero message and `message_mux_none.
  - Output data and controls hold until the next emission. message_en is 0 otherwise.
  - Latency: the eop word of the third message at cycle N gives message_en at N+1.
- Slots clear at emission. A message completing in the emission cycle lands in the new group's slot 0; no loss, no stall.
- Timeout counter:
  - Counts only while slot_cnt > 0 and FSM is IDLE.
  - Resets on any accepted in_valid or on emission. Saturates.
- Simultaneous triggers (third eop + flush + timeout): single emission.
- flush with slot_cnt = 0: no strobe.
- No backpressure: input is accepted every cycle.
- Reset mid-message or mid-group: all state and partial data discarded, no strobe.

Decomposition:
- Shared definitions in para_def.v:
  - `MAX_MESSAGE_BITS.
  - `message_mux_control_width.
  - `message_mux_a/d/k.
  - New `message_mux_none (all ones).
  - Type-byte constants.
- One natural sub-module: stage4_word_packer_module.
  - Holds the assembly register, word index and overlength detect.
  - The group FSM, slots and output stay in the top module.

Test Plan:
- Three single-word messages with type 0x41, 0x44, 0x4B, eop on cycles 1,2,3 -> message_en high on cycle 4 only; m1/m2/m3 = a/d/k codes; each message occupies the top 64 bits and the rest are 0.
- Two-word 'A' message, then idle 16 cycles -> message_en after timeout; m1 = a; m2, m3 = none; message_2 and message_3 = 0.
- Message with type 0x5A -> drop_err pulse; no slot consumed; a following three valid messages still emit one full group.
- Message of `MAX_MESSAGE_BITS/DATA_WIDTH + 1 words -> drop_err on the overflow word; remaining words ignored until eop; next message assembles correctly.
- sop arriving mid-message -> drop_err; the new message is intact in slot 0; flush then emits it with m2, m3 = none.
- Assert rst_n low while two slots are filled and a message is half assembled -> all outputs 0 and controls none immediately; no message_en after release.
